// File: rtl/ack_nak_pkg.sv
// Shared types and default widths for the ACK/NAK generator and its timer.
package ack_nak_pkg;

  localparam int DEF_SEQ_W  = 8;
  localparam int DEF_DATA_W = 129;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK_PEND,
    ST_NAK_WAIT
  } state_e;

  typedef enum logic [1:0] {
    IN_ORDER,
    DUP,
    AHEAD,
    BAD
  } pkt_class_e;

endpackage

// File: rtl/ack_nak_timer.sv
// Forced-ACK timer: counts cycles spent in ACK_PEND and flags expiry.
// Only instantiated when ACK_TIMER_EN is defined.
module ack_nak_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  assign expire_o = run_i && (count_q == CW'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i || !run_i) begin
      count_d = '0;
    end else if (!expire_o) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ack_nak_gen.sv
// Receive-side ACK/NAK generator: in-order delivery, coalesced ACKs, single NAK per gap.
// Define ACK_TIMER_EN to enable threshold coalescing with a forced-ACK timeout.
module ack_nak_gen
  import ack_nak_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SEQ_W       = DEF_SEQ_W,
  parameter int ACK_THRESH  = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [SEQ_W-1:0]  rx_seq,
  input  logic              rx_err,
  input  logic [DATA_W-1:0] rx_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              ack,
  output logic              nak,
  output logic [SEQ_W-1:0]  ack_seq
);

`ifdef ACK_TIMER_EN
  localparam int THRESH = ACK_THRESH;
`else
  // Without the timer nothing may linger unacknowledged, so every packet acks at once.
  localparam int THRESH = (ACK_THRESH + ACK_TIMEOUT > 0) ? 1 : 1;
`endif
  localparam int PW = $clog2(THRESH + 1);

  state_e            state_q, state_d;
  logic [SEQ_W-1:0]  exp_seq_q, exp_seq_d;
  logic [PW-1:0]     pend_q, pend_d;
  logic [SEQ_W-1:0]  seq_diff;
  pkt_class_e        pkt_class;
  logic              deliver, send_ack, send_nak, tmr_expire;

  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dv_q, dv_d;
  logic              ack_q, ack_d;
  logic              nak_q, nak_d;
  logic [SEQ_W-1:0]  ack_seq_q, ack_seq_d;

  // A negative modular distance means the transmitter is replaying old data.
  assign seq_diff = rx_seq - exp_seq_q;

  always_comb begin
    if (rx_err) begin
      pkt_class = BAD;
    end else if (seq_diff == '0) begin
      pkt_class = IN_ORDER;
    end else if (seq_diff[SEQ_W-1]) begin
      pkt_class = DUP;
    end else begin
      pkt_class = AHEAD;
    end
  end

`ifdef ACK_TIMER_EN
  ack_nak_timer #(
    .TIMEOUT (ACK_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .run_i    (state_q == ST_ACK_PEND),
    .clear_i  (send_ack || send_nak),
    .expire_o (tmr_expire)
  );
`else
  assign tmr_expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      exp_seq_q <= '0;
      pend_q    <= '0;
      dout_q    <= '0;
      dv_q      <= 1'b0;
      ack_q     <= 1'b0;
      nak_q     <= 1'b0;
      ack_seq_q <= '1;
    end else begin
      state_q   <= state_d;
      exp_seq_q <= exp_seq_d;
      pend_q    <= pend_d;
      dout_q    <= dout_d;
      dv_q      <= dv_d;
      ack_q     <= ack_d;
      nak_q     <= nak_d;
      ack_seq_q <= ack_seq_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    exp_seq_d = exp_seq_q;
    pend_d    = pend_q;
    deliver   = 1'b0;
    send_nak  = 1'b0;
    send_ack  = 1'b0;

    if (rx_valid) begin
      case (state_q)
        ST_NAK_WAIT: begin
          if (pkt_class == IN_ORDER) begin
            deliver = 1'b1;
            pend_d  = PW'(1);
            state_d = ST_ACK_PEND;
          end
        end
        default: begin
          case (pkt_class)
            IN_ORDER: begin
              deliver = 1'b1;
              pend_d  = pend_q + PW'(1);
              state_d = ST_ACK_PEND;
            end
            DUP: begin
              // A replay means the transmitter missed our ACK; make sure one goes out.
              if (pend_q == '0) begin
                pend_d = PW'(1);
              end
              state_d = ST_ACK_PEND;
            end
            default: begin
              send_nak = 1'b1;
              pend_d   = '0;
              state_d  = ST_NAK_WAIT;
            end
          endcase
        end
      endcase
    end

    if (deliver) begin
      exp_seq_d = exp_seq_q + SEQ_W'(1);
    end

    if (!send_nak && ((pend_d == PW'(THRESH)) || tmr_expire)) begin
      send_ack = 1'b1;
      pend_d   = '0;
      state_d  = ST_IDLE;
    end
  end

  // Output logic
  always_comb begin
    dv_d      = deliver;
    dout_d    = deliver ? rx_data : dout_q;
    ack_d     = send_ack;
    nak_d     = send_nak;
    ack_seq_d = ack_seq_q;
    if (send_ack || send_nak) begin
      ack_seq_d = exp_seq_d - SEQ_W'(1);
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign ack        = ack_q;
  assign nak        = nak_q;
  assign ack_seq    = ack_seq_q;

endmodule

// File: tb/tb_ack_nak_gen.sv
// Scoreboard bench for ack_nak_gen: directed scenarios plus randomized traffic
// checked against a rule-level reference model (honours ACK_TIMER_EN).
module tb_ack_nak_gen;

  localparam int DATA_W      = 129;
  localparam int SEQ_W       = 8;
  localparam int ACK_THRESH  = 4;
  localparam int ACK_TIMEOUT = 64;
  localparam int MOD         = 1 << SEQ_W;
`ifdef ACK_TIMER_EN
  localparam int THRESH = ACK_THRESH;
  localparam bit TIMER  = 1'b1;
`else
  localparam int THRESH = 1;
  localparam bit TIMER  = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              rx_valid = 1'b0;
  logic [SEQ_W-1:0]  rx_seq = '0;
  logic              rx_err = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic [DATA_W-1:0] dout;
  logic              dout_valid, ack, nak;
  logic [SEQ_W-1:0]  ack_seq;

  ack_nak_gen #(
    .DATA_W      (DATA_W),
    .SEQ_W       (SEQ_W),
    .ACK_THRESH  (ACK_THRESH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_seq     (rx_seq),
    .rx_err     (rx_err),
    .rx_data    (rx_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .ack        (ack),
    .nak        (nak),
    .ack_seq    (ack_seq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] data;
  } dexp_t;

  typedef struct {
    int               cyc;
    bit               is_ack;
    logic [SEQ_W-1:0] seq;
  } hexp_t;

  dexp_t dq[$];
  hexp_t hq[$];
  dexp_t de;
  hexp_t he;

  // Reference model state
  int m_exp, m_pending, m_since;
  bit m_nak_wait;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name, input int due);
    checks++;
    errors++;
    $display("FAIL %s: expected at cycle %0d, not seen by cycle %0d", name, due, cyc);
  endtask

  task automatic model_reset();
    m_exp = 0;
    m_pending = 0;
    m_since = 0;
    m_nak_wait = 1'b0;
    dq.delete();
    hq.delete();
  endtask

  // Predicts what the DUT shows after the coming rising edge (cycle t).
  task automatic model_step(input bit v, input logic [SEQ_W-1:0] seq, input bit err,
                            input logic [DATA_W-1:0] d);
    int t;
    int diff;
    bit was_pend;
    bit do_nak;
    bit do_ack;
    t = cyc + 1;
    was_pend = (m_pending > 0);
    do_nak = 1'b0;
    do_ack = 1'b0;
    if (v) begin
      diff = (int'(seq) - m_exp + MOD) % MOD;
      if (m_nak_wait) begin
        if (!err && diff == 0) begin
          dq.push_back('{t, d});
          m_exp = (m_exp + 1) % MOD;
          m_pending = 1;
          m_since = t;
          m_nak_wait = 1'b0;
        end
      end else if (!err && diff == 0) begin
        dq.push_back('{t, d});
        m_exp = (m_exp + 1) % MOD;
        if (m_pending == 0) m_since = t;
        m_pending++;
      end else if (!err && diff >= MOD / 2) begin
        if (m_pending == 0) begin
          m_pending = 1;
          m_since = t;
        end
      end else begin
        do_nak = 1'b1;
        m_pending = 0;
        m_nak_wait = 1'b1;
      end
    end
    if (!do_nak && m_pending >= THRESH) do_ack = 1'b1;
    if (TIMER && !do_nak && was_pend && t == m_since + ACK_TIMEOUT) do_ack = 1'b1;
    if (do_nak) begin
      hq.push_back('{t, 1'b0, SEQ_W'((m_exp - 1 + MOD) % MOD)});
    end else if (do_ack) begin
      hq.push_back('{t, 1'b1, SEQ_W'((m_exp - 1 + MOD) % MOD)});
      m_pending = 0;
    end
  endtask

  task automatic send(input bit v, input int seq, input bit err);
    logic [DATA_W-1:0] d;
    d = DATA_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
    @(negedge clk);
    rx_valid = v;
    rx_seq   = SEQ_W'(((seq % MOD) + MOD) % MOD);
    rx_err   = err;
    rx_data  = d;
    model_step(v, rx_seq, err, d);
    if (v) $display("pkt cyc=%0d seq=%0d err=%0d exp_model=%0d", cyc + 1, rx_seq, err, m_exp);
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 0, 1'b0);
  endtask

  task automatic reset_checks();
    logic [SEQ_W-1:0] all1;
    all1 = '1;
    chk("reset dout_valid", 256'(dout_valid), 256'(0));
    chk("reset dout", 256'(dout), 256'(0));
    chk("reset ack", 256'(ack), 256'(0));
    chk("reset nak", 256'(nak), 256'(0));
    chk("reset ack_seq", 256'(ack_seq), 256'(all1));
  endtask

  // with_pkt leaves a packet on the bus that reset prevents from ever being sampled.
  task automatic do_reset(input bit with_pkt);
    @(negedge clk);
    rx_valid = with_pkt;
    rx_seq   = SEQ_W'(m_exp);
    rx_err   = 1'b0;
    #1 reset = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      reset_checks();
    end
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  always @(negedge clk) begin
    if (reset) begin
      while (dq.size() > 0 && dq[0].cyc < cyc) begin
        miss("dout_valid missing", dq[0].cyc);
        dq.delete(0);
      end
      while (hq.size() > 0 && hq[0].cyc < cyc) begin
        miss("ack/nak missing", hq[0].cyc);
        hq.delete(0);
      end
      if (dout_valid) begin
        if (dq.size() == 0) begin
          miss("spurious dout_valid", cyc);
        end else begin
          de = dq.pop_front();
          chk("dout cycle", 256'(cyc), 256'(de.cyc));
          chk("dout data", 256'(dout), 256'(de.data));
          $display("deliver cyc=%0d", cyc);
        end
      end
      if (ack || nak) begin
        if (hq.size() == 0) begin
          miss("spurious ack/nak", cyc);
        end else begin
          he = hq.pop_front();
          chk("hs cycle", 256'(cyc), 256'(he.cyc));
          chk("ack", 256'(ack), 256'(he.is_ack));
          chk("nak", 256'(nak), 256'(!he.is_ack));
          chk("ack_seq", 256'(ack_seq), 256'(he.seq));
          $display("%s cyc=%0d ack_seq=%0d", ack ? "ack" : "nak", cyc, ack_seq);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      reset_checks();
    end
    @(negedge clk);
    reset = 1'b1;

    // Clean burst
    for (int s = 0; s < 4; s++) send(1'b1, s, 1'b0);
    idle(3);

    // Gap, drop while waiting, recovery
    do_reset(1'b0);
    send(1'b1, 0, 1'b0);
    send(1'b1, 1, 1'b0);
    send(1'b1, 3, 1'b0);
    send(1'b1, 4, 1'b0);
    send(1'b1, 2, 1'b0);
    idle(3);

    // Corrupted first packet; seq 0 still expected afterwards
    do_reset(1'b0);
    send(1'b1, 0, 1'b1);
    idle(2);
    send(1'b1, 0, 1'b0);
    idle(3);

    // Replay after acceptance
    do_reset(1'b0);
    for (int s = 0; s < 5; s++) send(1'b1, s, 1'b0);
    idle(2);
    send(1'b1, 2, 1'b0);
    idle(ACK_TIMEOUT + 5);

    // Sequence wrap
    do_reset(1'b0);
    for (int s = 0; s < 254; s++) send(1'b1, s, 1'b0);
    idle(2);
    for (int s = 254; s < 258; s++) send(1'b1, s, 1'b0);
    idle(2);
    send(1'b1, 130, 1'b0);
    idle(2);
    send(1'b1, 128, 1'b0);
    idle(ACK_TIMEOUT + 5);

    // Reset with unacknowledged packets must never produce that ACK
    do_reset(1'b0);
    send(1'b1, 0, 1'b0);
    send(1'b1, 1, 1'b0);
    do_reset(1'b1);
    idle(ACK_TIMEOUT + 10);

    // Randomized traffic
    do_reset(1'b0);
    repeat (600) begin
      r = $urandom_range(0, 99);
      if (r < 8)       idle(1);
      else if (r < 70) send(1'b1, m_exp, 1'b0);
      else if (r < 78) send(1'b1, m_exp - int'($urandom_range(1, MOD / 2)), 1'b0);
      else if (r < 88) send(1'b1, m_exp + int'($urandom_range(1, MOD / 2 - 1)), 1'b0);
      else             send(1'b1, int'($urandom_range(0, MOD - 1)), 1'b1);
    end
    idle(ACK_TIMEOUT + 5);

    chk("deliveries outstanding", 256'(dq.size()), 256'(0));
    chk("ack/nak outstanding", 256'(hq.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
